// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmitter.
package ps2_pkg;

    // Transmitter FSM states
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        RELEASE
    } ps2_state_t;

    // Device clock falling edges in one host-to-device frame:
    // 8 data + parity + stop + ack
    localparam int FRAME_EDGES = 11;

    // Bits the host presents on falling edges (data, parity, stop)
    localparam int SHIFT_BITS = 10;

    // Odd parity bit: 1 when the byte holds an even number of ones
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 line plus falling-edge detect on the
// synchronized level. Flops reset to 1, the idle level of an open-collector line.
module ps2_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Metastability stages followed by a one-cycle history flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues the
// request-to-send, shifts a byte out on device clock falling edges and checks
// the device acknowledge, with a watchdog on every device-driven wait.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 15000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
    localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
    localparam int TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
    localparam int CNT_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam int IDX_W       = $clog2(SHIFT_BITS);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] STOP_IDX     = IDX_W'(SHIFT_BITS - 1);

    ps2_state_t             state_q;
    logic [7:0]             data_q;
    logic                   parity_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   clk_level;
    logic                   clk_fall;
    logic                   data_level;
    logic                   data_fall_unused;

    logic [SHIFT_BITS-1:0]  frame_bits;
    logic                   timed_out;

    ps2_sync u_sync_clk (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    // Data edges carry no meaning for the transmitter; only the level is used
    ps2_sync u_sync_data (
        .clk     (clk),
        .rst_n   (rst_n),
        .line_in (ps2_data_in),
        .level   (data_level),
        .fall    (data_fall_unused)
    );

    // Bits presented after the host-driven start bit, index 0 first
    assign frame_bits = {1'b1, parity_q, data_q};
    assign timed_out  = (cnt_q == TIMEOUT_LAST);
    assign tx_ready   = (state_q == IDLE);

    // Frame sequencer: line drive, bit index, shared inhibit/watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= 8'h00;
            parity_q    <= 1'b0;
            bit_idx_q   <= '0;
            cnt_q       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            cnt_q    <= cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    cnt_q       <= '0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid) begin
                        data_q     <= tx_data;
                        parity_q   <= odd_parity(tx_data);
                        ps2_clk_oe <= 1'b1;
                        state_q    <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (cnt_q == INHIBIT_LAST) begin
                        cnt_q       <= '0;
                        ps2_data_oe <= 1'b1;
                        state_q     <= START;
                    end
                end

                START: begin
                    // Start bit is already on the data line; hand the clock to the device
                    cnt_q      <= '0;
                    ps2_clk_oe <= 1'b0;
                    bit_idx_q  <= '0;
                    state_q    <= SHIFT;
                end

                SHIFT: begin
                    if (timed_out) begin
                        cnt_q       <= '0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        state_q     <= IDLE;
                    end else if (clk_fall) begin
                        cnt_q       <= '0;
                        ps2_data_oe <= ~frame_bits[bit_idx_q];
                        if (bit_idx_q == STOP_IDX) begin
                            ps2_data_oe <= 1'b0;
                            state_q     <= ACK;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end

                ACK: begin
                    if (timed_out) begin
                        cnt_q    <= '0;
                        tx_error <= 1'b1;
                        state_q  <= IDLE;
                    end else if (clk_fall) begin
                        cnt_q <= '0;
                        if (!data_level) begin
                            state_q <= RELEASE;
                        end else begin
                            tx_error <= 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                end

                RELEASE: begin
                    if (timed_out) begin
                        cnt_q    <= '0;
                        tx_error <= 1'b1;
                        state_q  <= IDLE;
                    end else if (clk_level && data_level) begin
                        cnt_q   <= '0;
                        tx_done <= 1'b1;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    cnt_q       <= '0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector bus with a behavioural PS/2 device,
// a scoreboard of expected completions and a monitor that checks each pulse.
module tb_ps2_host_tx;

    localparam int CLK_HZ     = 50_000_000;
    localparam int INH_US     = 100;
    localparam int TO_US      = 200;
    localparam int INH_CYC    = CLK_HZ / 1_000_000 * INH_US;
    localparam int TO_CYC     = CLK_HZ / 1_000_000 * TO_US;
    localparam int WAIT_LIMIT = 20000;

    typedef struct {
        bit          exp_done;
        bit          chk_frame;
        logic [10:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       tx_done;
    logic       tx_error;
    logic       dev_clk_low;
    logic       dev_data_low;
    logic       ps2_clk_line;
    logic       ps2_data_line;

    exp_t        exp_q[$];
    logic [10:0] rx_frame;
    int          checks   = 0;
    int          failures = 0;
    int          pulses   = 0;
    int          inh_run  = 0;
    int          inh_last = 0;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .INHIBIT_US  (INH_US),
        .TIMEOUT_US  (TO_US)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    // Reference frame as seen on the wire: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        bit par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Length of the clock-only inhibit window preceding each start bit
    always @(negedge clk) begin
        if (ps2_clk_oe && !ps2_data_oe) begin
            inh_run++;
        end else begin
            if (ps2_data_oe && inh_run != 0) inh_last = inh_run;
            inh_run = 0;
        end
    end

    // Scoreboard monitor: every done/error pulse consumes one expected outcome
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (tx_done && tx_error) chk("done_error_overlap", 1, 0);
            if (tx_done || tx_error) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {tx_done, tx_error}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("outcome_done", tx_done, e.exp_done);
                    chk("outcome_error", tx_error, !e.exp_done);
                    if (e.chk_frame) chk("frame_bits", rx_frame, e.frame);
                    chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit exp_done, input bit chk_frame, input bit push);
        int n;
        exp_t e;
        n = 0;
        while (tx_ready !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", n < WAIT_LIMIT, 1);
        if (push) begin
            e.exp_done  = exp_done;
            e.chk_frame = chk_frame;
            e.frame     = model_frame(d);
            exp_q.push_back(e);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Device side. mode 0: ack, 1: no ack, 2: never clocks, 3: stop after 4 edges
    task automatic serve(input int mode, output bit ok);
        int n;
        int h;
        ok = 1'b0;
        n  = 0;
        while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("request_to_send", n < WAIT_LIMIT, 1);
        if (n >= WAIT_LIMIT) return;
        ok          = 1'b1;
        rx_frame    = '1;
        rx_frame[0] = ps2_data_line;
        if (mode == 2) return;
        h = 20;
        for (int e = 1; e <= 11; e++) begin
            h = $urandom_range(15, 30);
            repeat (h) @(negedge clk);
            if (e == 11) begin
                dev_data_low = (mode == 0);
                repeat (3) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (h) @(negedge clk);
            if (e <= 10) rx_frame[e] = ps2_data_line;
            if (e == 5) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
            end
            if (e == 7) tx_valid = 1'b0;
            dev_clk_low = 1'b0;
            if (mode == 3 && e == 4) return;
        end
        repeat (h) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_pulse(input int p0);
        int n;
        n = 0;
        while (pulses == p0 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("completion_seen", pulses != p0, 1);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] d, input int mode);
        bit ok;
        int p0;
        p0 = pulses;
        send(d, mode == 0, 1'b1, 1'b1);
        serve(mode, ok);
        if (ok) wait_pulse(p0);
        chk("inhibit_cycles", inh_last, INH_CYC);
        chk("ready_after_frame", tx_ready, 1);
    endtask

    initial begin
        bit ok;
        int n;
        int p0;

        rst_n        = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_clk_oe", ps2_clk_oe, 0);
        chk("reset_data_oe", ps2_data_oe, 0);
        chk("reset_done", tx_done, 0);
        chk("reset_error", tx_error, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", tx_ready, 1);

        run_frame(8'hED, 0);
        chk("frame_ed_literal", rx_frame, {1'b1, 1'b1, 8'hED, 1'b0});
        run_frame(8'h01, 0);
        chk("parity_01", rx_frame[9], 0);
        run_frame(8'hFF, 0);
        chk("parity_ff", rx_frame[9], 1);
        for (int i = 0; i < 2; i++) run_frame(8'($urandom), 0);

        // Device leaves data high on the acknowledge edge
        run_frame(8'($urandom), 1);

        // Device never clocks after the request-to-send
        p0 = pulses;
        send(8'($urandom), 1'b0, 1'b0, 1'b1);
        serve(2, ok);
        n = 0;
        if (ok) begin
            while (!tx_error && n < TO_CYC + 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("timeout_cycles", n, TO_CYC);
        @(negedge clk);
        chk("timeout_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("timeout_single_pulse", pulses - p0, 1);
        chk("timeout_inhibit_cycles", inh_last, INH_CYC);

        // Reset in the middle of a frame: d3 of 0xA5 is 0, so data is driven low
        p0 = pulses;
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        serve(3, ok);
        @(negedge clk);
        chk("data_oe_mid_frame", ps2_data_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_drop_clk_oe", ps2_clk_oe, 0);
        chk("reset_drop_data_oe", ps2_data_oe, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_reset", tx_ready, 1);
        chk("no_pulse_on_reset", pulses - p0, 0);

        run_frame(8'hF4, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
